// File: rtl/dbus_mem_responder.sv
// Data-bus responder backed by a word-addressed 64-bit RAM with addr_ok/data_ok handshake.
// Optional DBUS_RESP_STALL_EN adds 0-3 pseudo-random extra wait cycles per transaction.
module dbus_mem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [139:0] dreq,
  output logic [65:0]  dresp
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(LATENCY + 4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          data_ok_q;
  logic [63:0]   data_q;
  logic [63:0]   held;

  logic          valid;
  logic [63:0]   addr;
  logic [7:0]    strobe;
  logic [63:0]   wdata;
  logic [63:0]   off;
  logic          inrange;
  logic [AW-1:0] idx;
  logic          accept;
  logic [63:0]   rword;
  logic [63:0]   merged;
  logic [63:0]   result;
  logic [1:0]    extra;
  logic [CW-1:0] load;
  logic          unused_ok;

  logic [63:0] mem [MEM_WORDS];

  assign valid   = dreq[139];
  assign addr    = dreq[138:75];
  assign strobe  = dreq[71:64];
  assign wdata   = dreq[63:0];
  // size is carried on the bus but never consulted: whole words are always returned
  assign unused_ok = &{1'b0, dreq[74:72]};

  assign off     = addr - BASE_ADDR;
  assign inrange = off < (64'(MEM_WORDS) << 3);
  assign idx     = off[AW+2:3];
  assign accept  = (state == IDLE) && valid && !reset;
  assign rword   = inrange ? mem[idx] : '0;

  always_comb begin
    merged = rword;
    for (int unsigned i = 0; i < 8; i++) begin
      if (strobe[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
    end
  end

  assign result = inrange ? merged : '0;

`ifdef DBUS_RESP_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign extra = lfsr[1:0];
`else
  assign extra = '0;
`endif

  assign load = CW'(LATENCY - 1) + CW'(extra);

  // Writes commit at the acceptance edge, so a later reset cannot undo them.
  always_ff @(posedge clk) begin
    if (accept && inrange && (strobe != '0)) mem[idx] <= merged;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      data_ok_q <= 1'b0;
      data_q    <= '0;
      held      <= '0;
    end else begin
      case (state)
        IDLE: begin
          data_ok_q <= 1'b0;
          if (accept) begin
            held <= result;
            cnt  <= load;
            if (load == '0) begin
              state     <= RESP;
              data_ok_q <= 1'b1;
              data_q    <= result;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state     <= RESP;
            data_ok_q <= 1'b1;
            data_q    <= held;
          end
        end
        RESP: begin
          data_ok_q <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          data_ok_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign dresp = {accept, data_ok_q, data_q};

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Randomized self-checking bench for dbus_mem_responder against a word-array scoreboard.
module tb_dbus_mem_responder;

  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned LAT       = 2;
  localparam logic [63:0] BASE      = 64'h8000_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic [139:0] dreq;
  logic [65:0]  dresp;

  logic        valid;
  logic [63:0] addr;
  logic [2:0]  size;
  logic [7:0]  strobe;
  logic [63:0] wdata;
  logic        addr_ok, data_ok;
  logic [63:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [63:0] model [16];

  assign dreq    = {valid, addr, size, strobe, wdata};
  assign addr_ok = dresp[65];
  assign data_ok = dresp[64];
  assign rdata   = dresp[63:0];

  dbus_mem_responder #(
    .MEM_WORDS(MEM_WORDS),
    .LATENCY  (LAT),
    .BASE_ADDR(BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .dreq (dreq),
    .dresp(dresp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drives one request (valid left high afterwards) and returns response data,
  // cycles from acceptance to data_ok, and the cycle number of acceptance.
  task automatic txn(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                     output logic [63:0] rd, output int lat, output int tacc);
    int k;
    addr = a; strobe = s; wdata = d; size = 3'd3; valid = 1'b1;
    #1;
    k = 0;
    while (!addr_ok && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check("accept", {63'b0, addr_ok}, 64'd1);
    tacc = cyc;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (addr_ok) check("reaccept", {63'b0, addr_ok}, 64'd0);
    end while (!data_ok && lat < 20);
    check("data_ok", {63'b0, data_ok}, 64'd1);
    rd = rdata;
    @(posedge clk); #1;
    check("data_ok_pulse", {63'b0, data_ok}, 64'd0);
  endtask

  task automatic op(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                    output logic [63:0] rd, output int lat, output int tacc);
    logic [63:0] off, exp, w;
    off = a - BASE;
    exp = 64'h0;
    if (off < 64'(MEM_WORDS) * 8 && (off >> 3) < 16) begin
      w = model[off[6:3]];
      for (int b = 0; b < 8; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
      if (s != 8'h00) model[off[6:3]] = w;
      exp = w;
    end
    txn(a, s, d, rd, lat, tacc);
    check("data", rd, exp);
`ifdef DBUS_RESP_STALL_EN
    check("lat_range", {63'b0, (lat >= int'(LAT) && lat <= int'(LAT) + 3)}, 64'd1);
`else
    check("lat", 64'(lat), 64'(LAT));
`endif
  endtask

  initial begin
    logic [63:0] rd;
    int lat, ta, ta_prev, lat_prev, c0;
    logic [63:0] a;
    logic [7:0]  s;

    reset = 1'b1; valid = 1'b0; addr = '0; size = '0; strobe = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr_ok", {63'b0, addr_ok}, 64'd0);
    check("rst_data_ok", {63'b0, data_ok}, 64'd0);
    check("rst_data", rdata, 64'h0);
    valid = 1'b1; #1;
    check("rst_gate_addr_ok", {63'b0, addr_ok}, 64'd0);
    valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      op(BASE + 64'(i) * 8, 8'hFF, {$urandom, $urandom}, rd, lat, ta);
      valid = 1'b0;
    end

    op(64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, rd, lat, ta);
    check("full_write_resp", rd, 64'h1122_3344_5566_7788);
    valid = 1'b0; @(posedge clk); #1;
    op(64'h8000_0010, 8'h00, 64'h0, rd, lat, ta);
    check("full_read", rd, 64'h1122_3344_5566_7788);
    valid = 1'b0;
    op(64'h8000_0010, 8'h0F, 64'hFFFF_FFFF_AAAA_BBBB, rd, lat, ta);
    valid = 1'b0;
    op(64'h8000_0014, 8'h00, 64'h0, rd, lat, ta);
    check("partial_read", rd, 64'h1122_3344_AAAA_BBBB);

    op(64'h8000_0010, 8'h00, 64'h0, rd, lat_prev, ta_prev);
    for (int i = 0; i < 3; i++) begin
      op(64'h8000_0010, 8'h00, 64'h0, rd, lat, ta);
      check("b2b_spacing", 64'(ta - ta_prev), 64'(lat_prev + 1));
      ta_prev = ta; lat_prev = lat;
    end
    valid = 1'b0;

    op(64'h7FFF_FFF8, 8'h00, 64'h0, rd, lat, ta);
    check("oor_low", rd, 64'h0);
    op(64'h8000_2000, 8'h00, 64'h0, rd, lat, ta);
    check("oor_high", rd, 64'h0);
    op(64'h8000_2000, 8'hFF, 64'hBAD0_BAD0_BAD0_BAD0, rd, lat, ta);
    valid = 1'b0;
    op(BASE, 8'h00, 64'h0, rd, lat, ta);
    check("oor_write_dropped", rd, model[0]);
    valid = 1'b0;

    addr = BASE + 64'd40; strobe = 8'hFF; wdata = 64'hDEAD; size = 3'd3; valid = 1'b1;
    #1;
    check("rst_mid_accept", {63'b0, addr_ok}, 64'd1);
    model[5] = 64'hDEAD;
    @(posedge clk); #1;
    reset = 1'b1; valid = 1'b0; #1;
    check("rst_mid_data_ok", {63'b0, data_ok}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_mid_no_resp", {63'b0, data_ok}, 64'd0);
    end
    c0 = cyc;
    op(BASE + 64'd40, 8'h00, 64'h0, rd, lat, ta);
    check("rst_mid_idle", 64'(ta - c0), 64'd0);
    check("rst_mid_committed", rd, 64'hDEAD);
    valid = 1'b0;

    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0:       a = BASE - 64'($urandom_range(1, 64));
          1:       a = BASE + 64'(MEM_WORDS) * 8 + 64'($urandom_range(0, 4096));
          default: a = 64'($urandom);
        endcase
      end else begin
        a = BASE + 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(0, 7));
      end
      s = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      op(a, s, {$urandom, $urandom}, rd, lat, ta);
      if ($urandom_range(0, 1) == 0) begin
        valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
